// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_BITS = 8;

    localparam logic [OP_BITS-1:0] OP_ADD  = 8'h00;
    localparam logic [OP_BITS-1:0] OP_SUB  = 8'h01;
    localparam logic [OP_BITS-1:0] OP_MUL  = 8'h02;
    localparam logic [OP_BITS-1:0] OP_DIV  = 8'h03;
    localparam logic [OP_BITS-1:0] OP_MOD  = 8'h04;
    localparam logic [OP_BITS-1:0] OP_LAND = 8'h05;
    localparam logic [OP_BITS-1:0] OP_LOR  = 8'h06;
    localparam logic [OP_BITS-1:0] OP_LNOT = 8'h07;
    localparam logic [OP_BITS-1:0] OP_BNOT = 8'h08;
    localparam logic [OP_BITS-1:0] OP_AND  = 8'h09;
    localparam logic [OP_BITS-1:0] OP_OR   = 8'h0A;
    localparam logic [OP_BITS-1:0] OP_XOR  = 8'h0B;
    localparam logic [OP_BITS-1:0] OP_SHL  = 8'h0C;
    localparam logic [OP_BITS-1:0] OP_SHR  = 8'h0D;
    localparam logic [OP_BITS-1:0] OP_INC  = 8'h0E;
    localparam logic [OP_BITS-1:0] OP_DEC  = 8'h0F;
    localparam logic [OP_BITS-1:0] OP_SAR  = 8'h10;
    localparam logic [OP_BITS-1:0] OP_SLT  = 8'h11;
    localparam logic [OP_BITS-1:0] OP_NOP  = 8'h80;

    localparam int unsigned NUM_FLAGS   = 5;
    localparam int unsigned FLG_ZERO    = 0;
    localparam int unsigned FLG_CARRY   = 1;
    localparam int unsigned FLG_OVF     = 2;
    localparam int unsigned FLG_DIV0    = 3;
    localparam int unsigned FLG_ILLEGAL = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per divide.
// quotient/remainder are valid combinationally in the cycle done is high.
module alu_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic             last;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        q_bit    = !trial[WIDTH];
        rem_step = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_step = {quo_q[WIDTH-2:0], q_bit};
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && last;
    assign quotient  = quo_step;
    assign remainder = rem_step;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops into a held result register, div/mod via
// the iterative divider with the input side stalled while it runs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPW   = 8
) (
    input  logic                 c,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPW-1:0]       op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SW  = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

    alu_state_e           state_q, state_d;
    logic                 div_mod_q, div_mod_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;

    logic                 accept;
    logic                 is_divmod;
    logic                 div_start;
    logic                 div_finish;
    logic                 div_busy;
    logic                 div_done;
    logic [WIDTH-1:0]     div_quo;
    logic [WIDTH-1:0]     div_rem;
    logic [WIDTH-1:0]     div_res;

    logic [WIDTH:0]       add_ext;
    logic [WIDTH:0]       sub_ext;
    logic [WIDTH:0]       inc_ext;
    logic [WIDTH:0]       dec_ext;
    logic                 shift_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic                 alu_div0;
    logic                 alu_illegal;
    logic                 alu_beat;
    logic [NUM_FLAGS-1:0] alu_flags;

    assign in_ready   = !rst && (state_q == ST_IDLE) && !div_busy && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_divmod  = (op == OPW'(OP_DIV)) || (op == OPW'(OP_MOD));
    assign div_start  = accept && is_divmod && (b != '0);
    assign div_finish = (state_q == ST_DIV) && div_done;
    assign div_res    = div_mod_q ? div_rem : div_quo;

    alu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .c         (c),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign add_ext   = {1'b0, a} + {1'b0, b};
    assign sub_ext   = {1'b0, a} - {1'b0, b};
    assign inc_ext   = {1'b0, a} + ONE_EXT;
    assign dec_ext   = {1'b0, a} - ONE_EXT;
    // Any amount bit at or above log2(WIDTH) shifts everything out.
    assign shift_big = |b[WIDTH-1:SW];

    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_div0    = 1'b0;
        alu_illegal = 1'b0;
        alu_beat    = 1'b1;
        case (op)
            OPW'(OP_ADD): begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
            end
            OPW'(OP_SUB): begin
                alu_res   = sub_ext[WIDTH-1:0];
                alu_carry = sub_ext[WIDTH];
                alu_ovf   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
            end
            OPW'(OP_MUL):  alu_res = a * b;
            OPW'(OP_DIV): begin
                alu_res  = '1;
                alu_div0 = (b == '0);
            end
            OPW'(OP_MOD): begin
                alu_res  = a;
                alu_div0 = (b == '0);
            end
            OPW'(OP_LAND): alu_res = {{(WIDTH-1){1'b0}}, (a != '0) && (b != '0)};
            OPW'(OP_LOR):  alu_res = {{(WIDTH-1){1'b0}}, (a != '0) || (b != '0)};
            OPW'(OP_LNOT): alu_res = {{(WIDTH-1){1'b0}}, (a == '0)};
            OPW'(OP_BNOT): alu_res = ~a;
            OPW'(OP_AND):  alu_res = a & b;
            OPW'(OP_OR):   alu_res = a | b;
            OPW'(OP_XOR):  alu_res = a ^ b;
            OPW'(OP_SHL):  alu_res = shift_big ? '0 : (a << b[SW-1:0]);
            OPW'(OP_SHR):  alu_res = shift_big ? '0 : (a >> b[SW-1:0]);
            OPW'(OP_SAR):  alu_res = shift_big ? {WIDTH{a[MSB]}}
                                               : WIDTH'($signed(a) >>> b[SW-1:0]);
            OPW'(OP_INC): begin
                alu_res   = inc_ext[WIDTH-1:0];
                alu_carry = inc_ext[WIDTH];
                alu_ovf   = !a[MSB] && inc_ext[MSB];
            end
            OPW'(OP_DEC): begin
                alu_res   = dec_ext[WIDTH-1:0];
                alu_carry = dec_ext[WIDTH];
                alu_ovf   = a[MSB] && !dec_ext[MSB];
            end
            OPW'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OPW'(OP_NOP):  alu_beat = 1'b0;
            default:       alu_illegal = 1'b1;
        endcase
        alu_flags              = '0;
        alu_flags[FLG_ZERO]    = (alu_res == '0);
        alu_flags[FLG_CARRY]   = alu_carry;
        alu_flags[FLG_OVF]     = alu_ovf;
        alu_flags[FLG_DIV0]    = alu_div0;
        alu_flags[FLG_ILLEGAL] = alu_illegal;
    end

    // Control FSM: IDLE accepts everything, DIV stalls until the divider finishes.
    always_comb begin
        state_d   = state_q;
        div_mod_d = div_mod_q;
        case (state_q)
            ST_IDLE: begin
                if (div_start) begin
                    state_d   = ST_DIV;
                    div_mod_d = (op == OPW'(OP_MOD));
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result slot: drain on out_ready, reload from either datapath.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && !div_start && alu_beat) begin
            out_d       = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
        end
        if (div_finish) begin
            out_d             = div_res;
            flags_d           = '0;
            flags_d[FLG_ZERO] = (div_res == '0);
            out_valid_d       = 1'b1;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_mod_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_mod_q   <= div_mod_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=64): hand-computed results, flags and timing.
module tb_alu_pipe;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB1 = 64'h8000_0000_0000_0000;

    logic        c;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic [4:0]  flags;

    int tests;
    int fails;
    int cnt;

    alu_pipe #(.WIDTH(64), .OPW(8)) dut (
        .c         (c),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op at a negedge; it is accepted on the following posedge.
    task automatic send(input string tag, input logic [7:0] o, input logic [63:0] aa,
                        input logic [63:0] bb);
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge c);
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] res, input logic [4:0] fl);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"}, out, res);
        check({tag, "_flags"}, 64'(flags), 64'(fl));
    endtask

    task automatic one_op(input string tag, input logic [7:0] o, input logic [63:0] aa,
                          input logic [63:0] bb, input logic [63:0] res, input logic [4:0] fl);
        send(tag, o, aa, bb);
        expect_beat(tag, res, fl);
    endtask

    // Busy window must span exactly 64 cycles before the result appears.
    task automatic div_op(input string tag, input logic [7:0] o, input logic [63:0] aa,
                          input logic [63:0] bb, input logic [63:0] res);
        int low;
        send(tag, o, aa, bb);
        low = 0;
        for (int i = 0; i < 64; i++) begin
            if (!in_ready && !out_valid) low++;
            @(negedge c);
        end
        check({tag, "_busy_cycles"}, 64'(low), 64'd64);
        expect_beat(tag, res, 5'b00000);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 8'h00;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge c);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst = 1'b0;

        // Arithmetic, back-to-back with a drain on every accepting edge.
        one_op("add_carry", 8'h00, ONES, 64'd1, 64'd0, 5'b00011);
        one_op("sub_ovf", 8'h01, MSB1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00100);
        one_op("slt_neg", 8'h11, ONES, 64'd0, 64'd1, 5'b00000);
        one_op("sub_borrow", 8'h01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 5'b00010);
        one_op("inc_ovf", 8'h0E, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, MSB1, 5'b00100);
        one_op("dec_borrow", 8'h0F, 64'd0, 64'd0, ONES, 5'b00010);
        one_op("mul", 8'h02, 64'd3, 64'd5, 64'd15, 5'b00000);
        one_op("land", 8'h05, 64'd5, 64'd0, 64'd0, 5'b00001);
        one_op("lnot", 8'h07, 64'd0, 64'd9, 64'd1, 5'b00000);
        one_op("xor", 8'h0B, 64'hF0F0, 64'hFF00, 64'h0FF0, 5'b00000);
        one_op("bnot", 8'h08, 64'd0, 64'd0, ONES, 5'b00000);

        // Division timing and results, then divide-by-zero single-cycle path.
        div_op("div", 8'h03, 64'd100, 64'd7, 64'd14);
        div_op("mod", 8'h04, 64'd100, 64'd7, 64'd2);
        one_op("div0", 8'h03, 64'd100, 64'd0, ONES, 5'b01000);
        one_op("mod0", 8'h04, 64'd5, 64'd0, 64'd5, 5'b01000);
        @(negedge c);
        check("idle_drained", 64'(out_valid), 64'd0);

        // Backpressure: first result held, second op stalled until out_ready.
        out_ready = 1'b0;
        send("bp1", 8'h00, 64'd1, 64'd1);
        expect_beat("bp1", 64'd2, 5'b00000);
        in_valid = 1'b1;
        op       = 8'h00;
        a        = 64'd2;
        b        = 64'd2;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (!in_ready && out_valid && out == 64'd2) cnt++;
            @(negedge c);
        end
        check("bp_hold_cycles", 64'(cnt), 64'd3);
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", 64'(in_ready), 64'd1);
        @(negedge c);
        expect_beat("bp2", 64'd4, 5'b00000);
        a = 64'd3;
        b = 64'd3;
        @(negedge c);
        in_valid = 1'b0;
        expect_beat("bp3", 64'd6, 5'b00000);
        @(negedge c);
        check("bp_no_extra", 64'(out_valid), 64'd0);

        // Shifts at and beyond the width, illegal opcode and nop.
        one_op("shl_big", 8'h0C, 64'd1, 64'd64, 64'd0, 5'b00001);
        one_op("shl", 8'h0C, 64'd1, 64'd63, MSB1, 5'b00000);
        one_op("shr", 8'h0D, 64'h80, 64'd3, 64'h10, 5'b00000);
        one_op("sar_big", 8'h10, MSB1, 64'd200, ONES, 5'b00000);
        one_op("sar", 8'h10, MSB1, 64'd4, 64'hF800_0000_0000_0000, 5'b00000);
        one_op("illegal", 8'h55, 64'd7, 64'd7, 64'd0, 5'b10001);
        send("nop", 8'h80, 64'd1, 64'd1);
        @(negedge c);
        check("nop_no_beat", 64'(out_valid), 64'd0);

        // Reset on DIV cycle 30 aborts without a beat.
        send("abort", 8'h03, 64'd100, 64'd7);
        repeat (29) @(negedge c);
        check("abort_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge c);
        check("abort_rst_valid", 64'(out_valid), 64'd0);
        check("abort_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 64'(in_ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge c);
            if (out_valid) cnt++;
        end
        check("abort_no_beat", 64'(cnt), 64'd0);
        one_op("post_abort_add", 8'h00, 64'd2, 64'd3, 64'd5, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised successor to the core integer ALU. Accepts one operation per handshake, computes single-cycle ops into a registered result stage, and runs division and modulo on an iterative divider. Results are held until the consumer accepts them. Two instances per core replace the free-running, always-clocked ALU pair, adding backpressure, status flags and defined corner-case results.

## Interface

**Parameters**
- WIDTH, 64, operand and result width in bits (≥ 8, power of two).
- OPW, 8, opcode width.

**Ports**
- c  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts operation this cycle.
- op  in  OPW  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- flags  out  5  {illegal, div0, ovf, carry, zero}.

## Operation

- **Opcodes:**
  - 0x00 add, 0x01 sub, 0x02 mul (low WIDTH bits).
  - 0x03 div (unsigned quotient), 0x04 mod (unsigned remainder).
  - 0x05 logical and, 0x06 logical or, 0x07 logical not (results 0 or 1).
  - 0x08 bitwise not, 0x09 and, 0x0A or, 0x0B xor.
  - 0x0C shl, 0x0D shr (logical), 0x10 sar (arithmetic).
  - 0x0E inc, 0x0F dec, 0x11 slt (signed a<b gives 1), 0x80 nop.
- **Shifts:** the amount is the full unsigned b. If b ≥ WIDTH, shl/shr give 0 and sar gives all copies of a[WIDTH-1].
- **Flags:**
  - carry: carry-out for add/inc; borrow for sub/dec.
  - ovf: signed overflow for add/sub/inc/dec.
  - zero: out==0 for every op.
  - carry and ovf are 0 for all other ops.
- **Divide by zero:** div gives all-ones and mod gives a. div0 is set.
- **Illegal opcode:** out=0, illegal=1, zero=1. It still produces a result beat.
- **nop:** accepted and produces no output beat.
- **FSM** (states IDLE, DIV):
  - IDLE, div/mod accepted, b≠0 → DIV. Dividend, divisor and op are latched.
  - DIV is a restoring divider, one quotient bit per cycle, WIDTH iterations.
  - On the final iteration the result register is loaded and the FSM returns to IDLE.
  - div/mod with b==0 completes as a single-cycle op; it does not enter DIV.
- **Handshake:**
  - in_ready = !rst && state==IDLE && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - out, flags and out_valid are stable while out_valid && !out_ready.

## Timing

- **Reset values:** out_valid=0, out=0, flags=0, state=IDLE, divider registers cleared. in_ready=0 during the reset cycle and 1 on the first cycle after.
- **Single-cycle ops:** accepted at edge t, out_valid=1 after edge t, i.e. visible in cycle t+1. Throughput is 1/cycle when out_ready=1.
- **Accept during drain:** a simultaneous result drain and new acceptance in the same cycle is legal. out_valid stays 1 and carries the new result.
- **div/mod (b≠0):**
  - Accepted at edge t; out_valid is visible in cycle t+WIDTH+1.
  - in_ready=0 for all DIV cycles.
  - A pending result is never overwritten: entering DIV requires in_ready, which guarantees the output slot is free or draining.
- **rst mid-division:** aborts the operation with no output beat. It also discards any held result.
- **Ignored inputs:** inputs while in_ready=0 are ignored; the source must hold them.

## Structure

- **Package alu_pkg:**
  - opcode localparams (OP_ADD … OP_SLT, OP_NOP).
  - flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_DIV0=3, FLG_ILLEGAL=4).
  - FSM state encoding.
- **Sub-module alu_divider:**
  - Parameter WIDTH.
  - Ports: c, rst, start, dividend, divisor, busy, done, quotient, remainder.
  - done pulses for exactly one cycle.
- **Top level:** alu_pipe contains the combinational single-cycle datapath, the result register, the handshake logic and the FSM.

## Test plan

- **Reset and add:** after rst, send add a=0xFFFF_FFFF_FFFF_FFFF, b=1 → out_valid next cycle, out=0, flags carry=1, zero=1, ovf=0.
- **Signed overflow:** sub a=0x8000_0000_0000_0000, b=1 → out=0x7FFF_FFFF_FFFF_FFFF, ovf=1. Then slt a=−1, b=0 → out=1.
- **Division:** div a=100, b=7 → in_ready low for 64 cycles, out=14, out_valid at cycle t+65. mod with the same operands → 2. div with b=0 → out=all-ones, div0=1 after 1 cycle.
- **Backpressure:** out_ready=0 with 3 back-to-back adds → the first result is held stable, in_ready=0, and the second op is not accepted until out_ready=1. Exactly 3 beats arrive in order.
- **Shifts and illegal:** shl a=1, b=64 → 0. sar a=0x8000…0, b=200 → all-ones. op=0x55 → out=0, illegal=1. nop → no beat.
- **Reset mid-operation:** rst asserted on DIV cycle 30 → no result beat, out_valid=0, in_ready=1 on the cycle after rst deasserts. The next add 2+3 → 5.
